// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol type and the four DVI control symbols.
package tmds_pkg;

  typedef logic [9:0] tmds_word_t;

  localparam tmds_word_t CTRL_00 = 10'b1101010100;
  localparam tmds_word_t CTRL_01 = 10'b0010101011;
  localparam tmds_word_t CTRL_10 = 10'b0101010100;
  localparam tmds_word_t CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with occupancy level and a registered ready.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_fwft #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_empty,
  output logic                           o_ready,
  output logic [$clog2(DEPTH+1)-1:0]     o_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [LVL_W-1:0] w_level_next;

  // Ready is registered, so it already reflects the current level: a push
  // it admits can never overflow.
  assign w_push       = i_push & r_ready;
  assign w_pop        = i_pop & (r_level != '0);
  assign w_level_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_level == '0);
  assign o_ready = r_ready;
  assign o_level = r_level;

  // Storage write.
  // NOTE: the data array has no reset; the level counter alone decides what
  // is valid, and leaving it unreset lets it map onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers, occupancy and the registered ready flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_next;
      r_ready <= (w_level_next < LVL_W'(DEPTH));
    end
  end

endmodule

// File: rtl/tmds_gearbox_nch.sv
// N-lane TMDS gearbox in the 5x serial clock domain: buffers 10-bit symbol
// sets and shifts them out LSB first as DDR bit pairs for external ODDRs,
// inserting an idle symbol when disabled or starved.
module tmds_gearbox_nch
  import tmds_pkg::*;
#(
  parameter int                 NUM_CH      = 4,
  parameter int                 WORD_W      = 10,
  parameter int                 FIFO_DEPTH  = 2,
  parameter logic [NUM_CH-1:0]  INVERT_MASK = '0,
  parameter logic [WORD_W-1:0]  IDLE_WORD   = WORD_W'(CTRL_00)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_CH*WORD_W-1:0]           in_data,
  output logic [NUM_CH-1:0]                  out_h,
  output logic [NUM_CH-1:0]                  out_l,
  output logic                               out_first,
  output logic                               underflow,
  output logic [15:0]                        underflow_cnt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int P    = WORD_W / 2;
  localparam int PH_W = (P > 1) ? $clog2(P) : 1;

  typedef logic [NUM_CH-1:0][WORD_W-1:0] lanes_t;

  logic [PH_W-1:0]   r_ph;
  lanes_t            r_sr;
  logic [NUM_CH-1:0] r_out_h;
  logic [NUM_CH-1:0] r_out_l;
  logic              r_out_first;
  logic              r_underflow;
  logic [15:0]       r_underflow_cnt;

  lanes_t            w_head;
  lanes_t            w_sel;
  logic              w_empty;
  logic              w_load;
  logic              w_pop;
  logic              w_starve;

  // The last phase of every symbol is the load slot; the phase counter
  // resets there so the first post-reset edge loads a fresh symbol.
  assign w_load   = (r_ph == PH_W'(P-1));
  assign w_pop    = w_load & enable & ~w_empty;
  assign w_starve = w_load & enable & w_empty;
  assign w_sel    = (enable && !w_empty) ? w_head : {NUM_CH{IDLE_WORD}};

  sync_fifo_fwft #(
    .WIDTH (NUM_CH*WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_ready (in_ready),
    .o_level (fifo_level)
  );

  // Phase counter: 0..P-1, wrapping after the load slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph <= PH_W'(P-1);
    end else if (w_load) begin
      r_ph <= '0;
    end else begin
      r_ph <= r_ph + PH_W'(1);
    end
  end

  // Per-lane shift registers and DDR output pair, inversion applied at the
  // output flops so P/N swaps cost no extra logic stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr        <= '0;
      r_out_h     <= '0;
      r_out_l     <= '0;
      r_out_first <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_load) begin
          r_sr[c]    <= w_sel[c] >> 2;
          r_out_h[c] <= w_sel[c][0] ^ INVERT_MASK[c];
          r_out_l[c] <= w_sel[c][1] ^ INVERT_MASK[c];
        end else begin
          r_sr[c]    <= r_sr[c] >> 2;
          r_out_h[c] <= r_sr[c][0] ^ INVERT_MASK[c];
          r_out_l[c] <= r_sr[c][1] ^ INVERT_MASK[c];
        end
      end
      r_out_first <= w_load;
    end
  end

  // Underflow pulse (aligned with out_first) and saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow     <= 1'b0;
      r_underflow_cnt <= '0;
    end else begin
      r_underflow <= w_starve;
      if (w_starve && (r_underflow_cnt != 16'hFFFF)) begin
        r_underflow_cnt <= r_underflow_cnt + 16'd1;
      end
    end
  end

  assign out_h         = r_out_h;
  assign out_l         = r_out_l;
  assign out_first     = r_out_first;
  assign underflow     = r_underflow;
  assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_tmds_gearbox_nch.sv
// Self-checking bench for tmds_gearbox_nch: a table of per-cycle output
// vectors for a single symbol, a scoreboard that reassembles every emitted
// symbol LSB first, and directed sequences for disable, inversion/sizing,
// reset mid-symbol and counter saturation.
module tb_tmds_gearbox_nch;
  import tmds_pkg::*;

  localparam int NC = 4;
  localparam int W  = 10;
  localparam int P  = 5;
  localparam int W8 = 8;
  localparam logic [NC*W-1:0] IDLE_SET = {NC{CTRL_00}};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable, in_valid, in_ready;
  logic [NC*W-1:0]   in_data;
  logic [NC-1:0]     out_h, out_l;
  logic              out_first, underflow;
  logic [15:0]       underflow_cnt;
  logic [1:0]        fifo_level;

  logic              en8, valid8, ready8;
  logic [NC*W8-1:0]  data8;
  logic [NC-1:0]     h8, l8;
  logic              first8, uf8;
  logic [15:0]       cnt8;
  logic [1:0]        level8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NC*W-1:0] sb[$];
  longint          hs_t[$];
  logic [NC*W-1:0] last_sym;
  int              sym_cnt = 0;
  int              uf_seen = 0;
  bit              mon_en  = 1'b0;

  typedef struct {
    logic          first;
    logic [NC-1:0] h;
    logic [NC-1:0] l;
    logic          uf;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  tmds_gearbox_nch dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_h(out_h), .out_l(out_l),
    .out_first(out_first), .underflow(underflow),
    .underflow_cnt(underflow_cnt), .fifo_level(fifo_level)
  );

  tmds_gearbox_nch #(
    .NUM_CH(NC), .WORD_W(W8), .FIFO_DEPTH(2),
    .INVERT_MASK(4'b0101), .IDLE_WORD(8'hA5)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .enable(en8), .in_valid(valid8),
    .in_ready(ready8), .in_data(data8), .out_h(h8), .out_l(l8),
    .out_first(first8), .underflow(uf8),
    .underflow_cnt(cnt8), .fifo_level(level8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait expired, expected event did not occur", name);
  endtask

  function automatic logic [NC*W-1:0] make_set(input int k);
    logic [NC*W-1:0] d;
    for (int c = 0; c < NC; c++) d[c*W +: W] = W'(k*4 + c + 1);
    return d;
  endfunction

  // Monitor: reassemble each symbol from out_first onwards, compare
  // non-idle symbols against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n && out_first) begin
      logic [NC*W-1:0] sym;
      bit              aborted;
      aborted = 1'b0;
      sym     = '0;
      for (int p = 0; p < P; p++) begin
        if (p > 0) @(negedge clk);
        if (!rst_n || !mon_en) aborted = 1'b1;
        for (int c = 0; c < NC; c++) begin
          sym[c*W + 2*p]     = out_h[c];
          sym[c*W + 2*p + 1] = out_l[c];
        end
      end
      if (!aborted) begin
        last_sym = sym;
        sym_cnt++;
        if (sym != IDLE_SET) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got %0h, expected no symbol", sym);
          end else begin
            check("sb_word", sym, sb.pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk) if (underflow) uf_seen++;

  task automatic push_set(input logic [NC*W-1:0] d);
    int b = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && b < 40) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) begin
      timeout("push_handshake");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(d);
    hs_t.push_back($time);
    #1;
  endtask

  task automatic release_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_first(input string name);
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!out_first && b < 20);
    if (!out_first) timeout(name);
  endtask

  task automatic drain(input string name);
    int b = 0;
    while (sb.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]     cnt_base;
    int              uf_base;
    int              sc;
    int              b;
    logic [NC*W-1:0] set_c;

    tbl[0] = '{1'b1, 4'b1110, 4'b1111, 1'b0};
    tbl[1] = '{1'b0, 4'b1110, 4'b1111, 1'b0};
    tbl[2] = '{1'b0, 4'b1110, 4'b1111, 1'b0};
    tbl[3] = '{1'b0, 4'b1110, 4'b1111, 1'b0};
    tbl[4] = '{1'b0, 4'b0000, 4'b0001, 1'b0};
    tbl[5] = '{1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[6] = '{1'b0, 4'b1111, 4'b0000, 1'b0};
    tbl[7] = '{1'b0, 4'b1111, 4'b0000, 1'b0};
    tbl[8] = '{1'b0, 4'b1111, 4'b0000, 1'b0};
    tbl[9] = '{1'b0, 4'b1111, 4'b1111, 1'b0};

    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    en8 = 1'b0; valid8 = 1'b0; data8 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_out_h", out_h, 0);
    check("rst_out_l", out_l, 0);
    check("rst_out_first", out_first, 0);
    check("rst_underflow", underflow, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_underflow_cnt", underflow_cnt, 0);
    check("rst_fifo_level", fifo_level, 0);

    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_first_load", out_first, 1);
    check("post_rst_disabled_no_uf", underflow, 0);
    mon_en = 1'b1;

    // Inversion and 8-bit sizing on the second instance
    @(negedge clk);
    valid8 = 1'b1;
    data8  = '0;
    check("w8_ready", ready8, 1);
    @(negedge clk);
    valid8 = 1'b0;
    en8    = 1'b1;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!first8 && b < 20);
    if (!first8) timeout("w8_first");
    for (int p = 0; p < 4; p++) begin
      if (p > 0) @(negedge clk);
      check("w8_inv_h", h8, 4'b0101);
      check("w8_inv_l", l8, 4'b0101);
      check("w8_first", first8, (p == 0));
    end
    @(negedge clk);
    check("w8_period4_first", first8, 1);
    check("w8_idle_h", h8, 4'b1010);
    check("w8_idle_l", l8, 4'b0101);
    check("w8_underflow", uf8, 1);

    // Single symbol, per-cycle table
    push_set({10'h0FF, 10'h0FF, 10'h0FF, 10'h2AA});
    release_in();
    check("single_level", fifo_level, 1);
    enable = 1'b1;
    wait_first("single_first");
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("single_first_flag", out_first, tbl[i].first);
      check("single_out_h", out_h, tbl[i].h);
      check("single_out_l", out_l, tbl[i].l);
      check("single_underflow", underflow, tbl[i].uf);
    end
    check("single_underflow_cnt", underflow_cnt, 1);

    // Back-to-back stream
    enable = 1'b0;
    wait_first("stream_dis0");
    wait_first("stream_dis1");
    cnt_base = underflow_cnt;
    hs_t.delete();
    for (int k = 0; k < 12; k++) begin
      if (k == 2) enable = 1'b1;
      push_set(make_set(k));
    end
    release_in();
    for (int i = 3; i < 12; i++) begin
      check("stream_ready_period", (hs_t[i] - hs_t[i-1]) / 10, P);
    end
    check("stream_no_underflow", underflow_cnt, cnt_base);
    drain("stream_drain");

    // Disable mid-symbol
    enable = 1'b0;
    wait_first("dis_idle0");
    wait_first("dis_idle1");
    push_set(make_set(100));
    push_set(make_set(101));
    release_in();
    check("dis_level_full", fifo_level, 2);
    enable = 1'b1;
    wait_first("dis_a_first");
    check("dis_ready_after_pop", in_ready, 1);
    set_c    = make_set(102);
    enable   = 1'b0;
    in_valid = 1'b1;
    in_data  = set_c;
    if (in_ready) sb.push_back(set_c);
    @(negedge clk);
    in_valid = 1'b0;
    cnt_base = underflow_cnt;
    uf_base  = uf_seen;
    sc       = sym_cnt;
    b = 0;
    while (sym_cnt < sc + 3 && b < 60) begin
      @(negedge clk);
      b++;
    end
    if (sym_cnt < sc + 3) timeout("dis_symbols");
    check("dis_idle_symbol", last_sym, IDLE_SET);
    check("dis_level_hold", fifo_level, 2);
    check("dis_no_underflow_cnt", underflow_cnt, cnt_base);
    check("dis_no_underflow_pulse", uf_seen, uf_base);
    enable = 1'b1;
    drain("dis_reenable_drain");

    // Reset mid-symbol
    push_set(make_set(200));
    release_in();
    wait_first("rst_mid_first");
    mon_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_h", out_h, 0);
    check("rstmid_out_l", out_l, 0);
    check("rstmid_out_first", out_first, 0);
    check("rstmid_in_ready", in_ready, 0);
    check("rstmid_underflow_cnt", underflow_cnt, 0);
    check("rstmid_fifo_level", fifo_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rstmid_first_after", out_first, 1);
    check("rstmid_ready_after", in_ready, 1);
    check("rstmid_underflow_after", underflow, 1);
    check("rstmid_cnt_after", underflow_cnt, 1);
    mon_en = 1'b1;

    // Saturation
    enable = 1'b0;
    wait_first("sat_dis0");
    wait_first("sat_dis1");
    force dut.r_underflow_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_underflow_cnt;
    @(negedge clk);
    check("sat_preset", underflow_cnt, 16'hFFFE);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_first("sat_first");
      check("sat_underflow_pulse", underflow, 1);
      check("sat_cnt", underflow_cnt, 16'hFFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
